// File: rtl/tdnn_pkg.sv
// Shared TDNN constants: per-bank layer offsets, bank geometry and the
// weight-load FSM encoding used by both the weight store and the generator.
package tdnn_pkg;

  localparam int WADDR_FC1 = 0;
  localparam int WADDR_B1  = 704;
  localparam int WADDR_FC2 = 736;
  localparam int WADDR_B2  = 1248;
  localparam int WADDR_FC3 = 1264;
  localparam int WADDR_B3  = 1296;

  localparam int BANK_SIZE = 1298;
  localparam int NUM_BANKS = 3;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/tdnn_weight_ram.sv
// Simple dual-port coefficient RAM: one write port, one registered read port,
// written so that synthesis maps it onto block RAM.
module tdnn_weight_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 3894
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: no reset on the array or its read register; a reset would block BRAM inference.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/tdnn_weight_store.sv
// Temperature-banked TDNN weight store: 1-cycle read port for the generator,
// idle-gated bank switching, and a streaming loader that rewrites inactive banks.
module tdnn_weight_store #(
  parameter int WEIGHT_WIDTH = 16,
  parameter int NUM_BANKS    = tdnn_pkg::NUM_BANKS,
  parameter int BANK_SIZE    = tdnn_pkg::BANK_SIZE,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   weight_addr,
  output logic [WEIGHT_WIDTH-1:0] weight_data,
  output logic [1:0]              weight_bank_sel,
  input  logic                    gen_busy,
  input  logic                    sel_req,
  input  logic [1:0]              sel_bank,
  output logic                    sel_err,
  input  logic                    load_start,
  input  logic [1:0]              load_bank,
  input  logic                    load_valid,
  input  logic [WEIGHT_WIDTH-1:0] load_data,
  output logic                    load_ready,
  output logic                    load_done,
  output logic                    load_err,
  output logic [NUM_BANKS-1:0]    bank_loaded
);
  import tdnn_pkg::*;

  localparam int DEPTH = NUM_BANKS * BANK_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(BANK_SIZE);

  load_state_e       state_q, state_n;
  logic [1:0]        ld_bank_q;
  logic [CW-1:0]     cnt_q;
  logic              load_accept, wr_en, cnt_last, load_bank_ok;
  logic [AW-1:0]     wr_addr;
  logic [3:0]        loaded_pad;
  logic              pend_valid_q, pend_valid_n, sel_ok, apply_sel;
  logic [1:0]        pend_bank_q, pend_bank_n;
  logic              rd_valid_q;
  logic [WEIGHT_WIDTH-1:0] ram_q;

  // Read path: out-of-range addresses (and the cycle after reset) read as zero.
  tdnn_weight_ram #(
    .WIDTH(WEIGHT_WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_addr),
    .wdata(load_data),
    .raddr(weight_addr[AW-1:0]),
    .rdata(ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= int'(weight_addr) < DEPTH;
  end

  assign weight_data = rd_valid_q ? ram_q : '0;

  // Bank index widened to 2 bits' range so bank 3 simply reads as unloaded.
  always_comb begin
    loaded_pad = '0;
    loaded_pad[NUM_BANKS-1:0] = bank_loaded;
  end

  assign cnt_last     = cnt_q == CW'(BANK_SIZE - 1);
  assign wr_addr      = AW'(int'(ld_bank_q) * BANK_SIZE + int'(cnt_q));
  assign load_bank_ok = (int'(load_bank) < NUM_BANKS) && (load_bank != weight_bank_sel) &&
                        !(pend_valid_q && (load_bank == pend_bank_q));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_n     = state_q;
    load_accept = 1'b0;
    wr_en       = 1'b0;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (load_start && load_bank_ok) begin
          load_accept = 1'b1;
          state_n     = LD_LOAD;
        end
      end
      LD_LOAD: begin
        load_ready = 1'b1;
        wr_en      = load_valid;
        if (load_valid && cnt_last) state_n = LD_DONE;
      end
      LD_DONE: begin
        load_done = 1'b1;
        state_n   = LD_IDLE;
      end
      default: state_n = LD_IDLE;
    endcase
  end

  assign load_err = load_start && !load_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      ld_bank_q   <= '0;
      cnt_q       <= '0;
      bank_loaded <= '0;
    end else begin
      state_q <= state_n;
      if (load_accept) begin
        ld_bank_q <= load_bank;
        cnt_q     <= '0;
      end else if (wr_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (load_accept && load_bank == 2'(b)) bank_loaded[b] <= 1'b0;
        if (load_done && ld_bank_q == 2'(b))   bank_loaded[b] <= 1'b1;
      end
    end
  end

  // A same-cycle load of the requested bank wins over the select.
  assign sel_ok       = sel_req && loaded_pad[sel_bank] &&
                        !(load_accept && (sel_bank == load_bank));
  assign sel_err      = sel_req && !sel_ok;
  assign pend_bank_n  = sel_ok ? sel_bank : pend_bank_q;
  assign pend_valid_n = sel_ok || pend_valid_q;
  assign apply_sel    = pend_valid_n && !gen_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_bank_sel <= '0;
      pend_valid_q    <= 1'b0;
      pend_bank_q     <= '0;
    end else if (apply_sel) begin
      weight_bank_sel <= pend_bank_n;
      pend_valid_q    <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_n;
      pend_bank_q  <= pend_bank_n;
    end
  end

endmodule
